led_share_arbiter: RTL and testbench

- Round-robin time-slice arbiter that shares the board's 4 user LEDs between up to four requesting display sources (e.g. binary seconds counter, switch mirror, status codes).
- Each source raises a request and presents a 4-bit pattern. The arbiter grants the LEDs to one source at a time for a fixed slice, then rotates among the active requesters.
- Sits between the display sources and the top-level leds pins.

---
 rtl/led_share_arbiter.sv | 179 +++++++++++++++++
 tb/tb_led_share_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/led_share_arbiter.sv
// led_share_arbiter
//   Round-robin time-slice arbiter that shares the four user LEDs among up
//   to four display sources. Each source raises req[i] and presents a 4-bit
//   pattern on pat[4i+3:4i]. The owner keeps the LEDs for one slice of
//   TICK_DIV*SLICE_TICKS cycles. After that the LEDs rotate to the next
//   active requester. A lone requester keeps its grant through silent
//   renewals.
//
// Parameters
//   TICK_DIV    clk cycles per slice tick (>= 2)
//   SLICE_TICKS ticks per grant slice (>= 1)
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   req[3:0]     per-source request
//   pat[15:0]    per-source LED patterns, nibble i = source i
//   grant[3:0]   registered one-hot grant, zero when nobody owns the LEDs
//   owner[1:0]   index of the current owner; holds the last owner when idle
//   owner_valid  high while any grant bit is set
//   leds[3:0]    registered LED drive
//
// Optional feature
//   Define LED_BLANK_GAP_EN to blank the LEDs for TICK_DIV cycles on every
//   change of owner. Renewals and releases to idle are not blanked.
module led_share_arbiter #(
  parameter int TICK_DIV    = 125000,
  parameter int SLICE_TICKS = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [15:0] pat,
  output logic [3:0]  grant,
  output logic [1:0]  owner,
  output logic        owner_valid,
  output logic [3:0]  leds
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SLICE_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLICE_MAX = SW'(SLICE_TICKS - 1);

`ifdef LED_BLANK_GAP_EN
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
`else
  typedef enum logic [0:0] {IDLE, GRANT} state_t;
`endif

  state_t        state, state_n;
  logic [3:0]    grant_n, leds_n;
  logic [1:0]    owner_n, last, last_n;
  logic [PW-1:0] presc, presc_n;
  logic [SW-1:0] slice, slice_n;
  logic [2:0]    pick;
  logic          tick, expire, others;

  // Round-robin search starting just after 'from'. 'from' itself is the
  // last candidate. The loop runs from the farthest candidate to the
  // nearest, so the nearest requester overwrites the result.
  // Bit 2 of the result flags that a requester was found.
  function automatic logic [2:0] select_next(input logic [3:0] r, input logic [1:0] from);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = from + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign pick        = select_next(req, last);
  assign tick        = (presc == PRESC_MAX);
  assign expire      = tick && (slice == SLICE_MAX);
  assign others      = (req & ~(4'b0001 << owner)) != 4'b0000;
  assign owner_valid = |grant;

  // State and output registers. Every output is registered, so leds and
  // grant never glitch combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= 4'b0000;
      owner <= 2'd0;
      last  <= 2'd3;
      presc <= '0;
      slice <= '0;
      leds  <= 4'b0000;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      last  <= last_n;
      presc <= presc_n;
      slice <= slice_n;
      leds  <= leds_n;
    end
  end

  // Next-state logic. In GRANT the owner's pattern is copied to the LEDs
  // every cycle. A release either hands over directly (or through GAP) or
  // drops to IDLE, where the LEDs go dark on the same edge as the grant.
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    last_n  = last;
    presc_n = presc;
    slice_n = slice;
    leds_n  = 4'b0000;
    case (state)
      IDLE: begin
        if (pick[2]) begin
          state_n = GRANT;
          grant_n = 4'b0001 << pick[1:0];
          owner_n = pick[1:0];
          last_n  = pick[1:0];
          presc_n = '0;
          slice_n = '0;
        end
      end
      GRANT: begin
        leds_n  = pat[{owner, 2'b00} +: 4];
        presc_n = tick ? '0 : presc + PW'(1);
        slice_n = tick ? slice + SW'(1) : slice;
        if (!req[owner] || (expire && others)) begin
          presc_n = '0;
          slice_n = '0;
          if (pick[2]) begin
`ifdef LED_BLANK_GAP_EN
            state_n = GAP;
            grant_n = 4'b0000;
            leds_n  = 4'b0000;
`else
            state_n = GRANT;
            grant_n = 4'b0001 << pick[1:0];
            owner_n = pick[1:0];
            last_n  = pick[1:0];
`endif
          end else begin
            state_n = IDLE;
            grant_n = 4'b0000;
            leds_n  = 4'b0000;
          end
        end else if (expire) begin
          // The lone requester renews its slice. The grant and the LEDs are untouched.
          presc_n = '0;
          slice_n = '0;
        end
      end
`ifdef LED_BLANK_GAP_EN
      GAP: begin
        // The prescaler times the blank interval. At its end, the arbiter
        // reselects from the requests present on that cycle.
        presc_n = presc + PW'(1);
        if (tick) begin
          presc_n = '0;
          slice_n = '0;
          if (pick[2]) begin
            state_n = GRANT;
            grant_n = 4'b0001 << pick[1:0];
            owner_n = pick[1:0];
            last_n  = pick[1:0];
          end else begin
            state_n = IDLE;
          end
        end
      end
`endif
      default: begin
        state_n = IDLE;
        grant_n = 4'b0000;
      end
    endcase
  end

endmodule

// File: tb/tb_led_share_arbiter.sv
// tb_led_share_arbiter
//   Self-checking bench for led_share_arbiter with TICK_DIV=4 and
//   SLICE_TICKS=3, which gives a 12-cycle slice. A behavioural model tracks
//   the owner, the round-robin pointer and the cycles elapsed in the
//   current slice. It then predicts grant, owner, owner_valid and leds.
//   The bench checks these predictions on every falling edge. Directed
//   scenarios add literal expectations, followed by a randomized phase.
module tb_led_share_arbiter;

  localparam int TD    = 4;
  localparam int ST    = 3;
  localparam int SLICE = TD * ST;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] pat;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        owner_valid;
  logic [3:0]  leds;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 0;

  // model state
  bit m_active = 0;
  int m_owner  = 0;
  int m_last   = 3;
  int m_age    = 0;
  int m_leds   = 0;

  led_share_arbiter #(.TICK_DIV(TD), .SLICE_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .req(req), .pat(pat),
    .grant(grant), .owner(owner), .owner_valid(owner_valid), .leds(leds)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Round-robin choice: the first requester after 'from', with 'from' itself last.
  function automatic int rr_pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++)
      if (r[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  // The model advances on the same edge as the DUT and uses the inputs that the DUT sees.
  always @(posedge clk) begin
    int p;
    int nl;
    p = rr_pick(req, m_last);
    if (rst) begin
      m_active = 0; m_owner = 0; m_last = 3; m_age = 0; m_leds = 0;
    end else if (!m_active) begin
      m_leds = 0;
      if (p >= 0) begin
        m_active = 1; m_owner = p; m_last = p; m_age = 0;
      end
    end else begin
      nl = int'(pat[4*m_owner +: 4]);
      if (!req[m_owner] || (m_age == SLICE - 1 && (req & ~(4'b0001 << m_owner)) != 0)) begin
        if (p >= 0) begin
          m_owner = p; m_last = p; m_age = 0; m_leds = nl;
        end else begin
          m_active = 0; m_leds = 0;
        end
      end else begin
        m_age  = (m_age == SLICE - 1) ? 0 : m_age + 1;
        m_leds = nl;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("grant", int'(grant), m_active ? (1 << m_owner) : 0);
      checkOutput("owner", int'(owner), m_owner);
      checkOutput("owner_valid", int'(owner_valid), int'(m_active));
      checkOutput("leds", int'(leds), m_leds);
    end
  end

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] p);
    @(posedge clk);
    #1;
    req = r;
    pat = p;
  endtask

  // Waits on falling edges until grant equals g. A timeout counts as a failure.
  task automatic waitGrant(input logic [3:0] g, input string name);
    int n;
    n = 0;
    while (grant !== g && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_timeout"}, int'(grant), int'(g));
  endtask

  initial begin
    int run;
    int bad;
    rst = 1; req = 4'b0000; pat = 16'h9C5A;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cmp_en = 1;
    @(negedge clk);
    checkOutput("reset_grant", int'(grant), 0);
    checkOutput("reset_ovalid", int'(owner_valid), 0);
    checkOutput("reset_leds", int'(leds), 0);
    checkOutput("reset_owner", int'(owner), 0);

    // A single request is granted one cycle later. Its pattern reaches the LEDs one cycle after that.
    applyStimulus(4'b0001, 16'h9C5A);
    @(posedge clk); @(negedge clk);
    checkOutput("first_grant", int'(grant), 1);
    checkOutput("first_leds_zero", int'(leds), 0);
    @(negedge clk);
    checkOutput("first_leds", int'(leds), 10);
    checkOutput("first_ovalid", int'(owner_valid), 1);

    // Two sources alternate with 12-cycle slices and a direct handover.
    applyStimulus(4'b0011, 16'h9C5A);
    @(negedge clk);
    waitGrant(4'b0010, "alt_to_1");
    run = 0;
    while (grant === 4'b0010 && run < 40) begin
      run++;
      @(negedge clk);
    end
    checkOutput("alt_slice_len", run, SLICE);
    checkOutput("alt_back_to_0", int'(grant), 1);

    // A lone source holds the LEDs through renewals without any dark cycle.
    applyStimulus(4'b0100, 16'h9C5A);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i >= 2 && (grant !== 4'b0100 || leds !== 4'hC)) bad++;
    end
    checkOutput("solo_renew_glitches", bad, 0);

    // Owner 0 drops its request mid-slice, so source 2 takes over on the next edge.
    applyStimulus(4'b0001, 16'h9C5A);
    @(posedge clk); @(negedge clk);
    checkOutput("drop_take0", int'(grant), 1);
    repeat (4) @(posedge clk);
    #1 req = 4'b0100;
    @(posedge clk); @(negedge clk);
    checkOutput("drop_grant2", int'(grant), 4);
    applyStimulus(4'b0000, 16'h9C5A);
    @(posedge clk); @(negedge clk);
    checkOutput("idle_grant", int'(grant), 0);
    checkOutput("idle_leds", int'(leds), 0);

    // A reset in the middle of a slice clears everything. Source 0 wins first afterwards.
    applyStimulus(4'b1111, 16'h9C5A);
    repeat (6) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); @(negedge clk);
    checkOutput("rst_grant", int'(grant), 0);
    checkOutput("rst_leds", int'(leds), 0);
    checkOutput("rst_ovalid", int'(owner_valid), 0);
    @(posedge clk);
    #1 rst = 0;
    @(posedge clk); @(negedge clk);
    checkOutput("rst_first_owner", int'(grant), 1);

    // Randomized traffic: requests stay steady for a while so that slices can expire.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 19) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) pat = 16'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    #1 rst = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
